// File: rtl/param_pattern_detector.sv
// ---------------------------------------------------------------------------
// param_pattern_detector
//
// Serial bit-pattern detector with a run-time loadable pattern of 2..MAX_LEN
// bits. It supports overlapping and non-overlapping detection. It also keeps
// a saturating match counter.
//
// Ports
//   clk              sole clock, rising edge
//   rst              synchronous reset, active low
//   d_in             serial data bit, used only when valid_in=1
//   valid_in         qualifies d_in
//   pat_load         one-cycle strobe loading pat_in / len_in / overlap_en
//   pat_in           pattern; bit len-1 is the first received bit
//   len_in           active pattern length
//   overlap_en       1 = overlapping detection, 0 = non-overlapping
//   clr_cnt          synchronous clear of match_count
//   pattern_detected registered one-cycle match pulse
//   match_count      saturating match counter
//   cfg_err          registered one-cycle pulse on an illegal load
//   armed            high while a legal pattern is loaded (FILL or RUN)
// ---------------------------------------------------------------------------
module param_pattern_detector #(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 16,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               d_in,
    input  logic               valid_in,
    input  logic               pat_load,
    input  logic [MAX_LEN-1:0] pat_in,
    input  logic [LEN_W-1:0]   len_in,
    input  logic               overlap_en,
    input  logic               clr_cnt,
    output logic               pattern_detected,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err,
    output logic               armed
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t             state;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic               overlap;
    logic [MAX_LEN-1:0] history;
    logic [LEN_W-1:0]   fill_cnt;

    logic [MAX_LEN-1:0] len_mask;
    logic [MAX_LEN-1:0] shifted;
    logic [LEN_W-1:0]   fill_next;
    logic               load_legal;
    logic               sample_ok;
    logic               hit;

    // Next-history, next-fill and match decode for the current valid sample.
    // Only the low len bits of history and pattern take part in the compare,
    // so a mask built from the active length hides the unused upper bits.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len));
        end
        shifted    = {history[MAX_LEN-2:0], d_in};
        fill_next  = (fill_cnt == len) ? len : fill_cnt + LEN_W'(1);
        load_legal = (32'(len_in) >= 32'd2) && (32'(len_in) <= 32'(MAX_LEN));
        // A load in the same cycle wins, so the data bit is discarded.
        sample_ok  = valid_in && !pat_load && (state != IDLE);
        hit        = sample_ok && (fill_next == len)
                     && ((shifted & len_mask) == (pattern & len_mask));
    end

    // Control FSM, datapath registers and registered outputs. The only way
    // back to IDLE is reset, so armed is set by a legal load and cleared
    // only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            pattern          <= '0;
            len              <= '0;
            overlap          <= 1'b0;
            history          <= '0;
            fill_cnt         <= '0;
            pattern_detected <= 1'b0;
            cfg_err          <= 1'b0;
            armed            <= 1'b0;
            match_count      <= '0;
        end else begin
            pattern_detected <= 1'b0;
            cfg_err          <= 1'b0;

            if (pat_load) begin
                if (load_legal) begin
                    pattern  <= pat_in;
                    len      <= len_in;
                    overlap  <= overlap_en;
                    history  <= '0;
                    fill_cnt <= '0;
                    state    <= FILL;
                    armed    <= 1'b1;
                end else begin
                    cfg_err  <= 1'b1;
                end
            end else if (sample_ok) begin
                history <= shifted;
                if (hit) begin
                    pattern_detected <= 1'b1;
                    // Non-overlap mode restarts filling so the next match
                    // is built only from fresh bits.
                    if (overlap) begin
                        fill_cnt <= fill_next;
                        state    <= RUN;
                    end else begin
                        fill_cnt <= '0;
                        state    <= FILL;
                    end
                end else begin
                    fill_cnt <= fill_next;
                    state    <= (fill_next == len) ? RUN : FILL;
                end
            end

            // A clear wins over a simultaneous match. The count holds at
            // all-ones instead of wrapping.
            if (clr_cnt) begin
                match_count <= '0;
            end else if (hit && (match_count != {CNT_W{1'b1}})) begin
                match_count <= match_count + CNT_W'(1);
            end
        end
    end

endmodule
